// File: rtl/johnson_pkg.sv
// ----------------------------------------------------------------------------
// johnson_pkg
// Shared constants and helper functions for the 8-stage Johnson counter.
//   JC_WIDTH   : number of register stages
//   JC_STATES  : length of the twisted-ring cycle (2*JC_WIDTH)
//   JC_PHASE_W : width of the decoded phase index
// ----------------------------------------------------------------------------
package johnson_pkg;

   localparam int JC_WIDTH   = 8;
   localparam int JC_STATES  = 2 * JC_WIDTH;
   localparam int JC_PHASE_W = $clog2(JC_STATES);

   // A Johnson state has at most one boundary between a run of ones and a
   // run of zeros, so counting adjacent-bit transitions identifies legality.
   function automatic logic jc_is_legal(input logic [JC_WIDTH-1:0] v);
      int unsigned trans;
      trans = 0;
      for (int i = 0; i < JC_WIDTH - 1; i++) begin
         if (v[i] != v[i+1]) begin
            trans = trans + 1;
         end
      end
      return (trans <= 1);
   endfunction

   // Popcount never exceeds JC_WIDTH, which always fits in JC_PHASE_W bits.
   function automatic logic [JC_PHASE_W-1:0] jc_popcount(input logic [JC_WIDTH-1:0] v);
      logic [JC_PHASE_W-1:0] acc;
      acc = {JC_PHASE_W{1'b0}};
      for (int i = 0; i < JC_WIDTH; i++) begin
         acc = acc + {{(JC_PHASE_W-1){1'b0}}, v[i]};
      end
      return acc;
   endfunction

endpackage : johnson_pkg

// File: rtl/johnson_phase_decoder.sv
// ----------------------------------------------------------------------------
// johnson_phase_decoder
// Combinational decode of a Johnson counter state.
//   count    in  : current register state (MSB = bit JC_WIDTH-1)
//   phase    out : position of count in the 2*JC_WIDTH cycle, 0 when illegal
//   terminal out : high on the last legal state (only the LSB set)
//   illegal  out : high when count is not a valid Johnson state
// ----------------------------------------------------------------------------
module johnson_phase_decoder
   import johnson_pkg::*;
(
   input  logic [JC_WIDTH-1:0]   count,
   output logic [JC_PHASE_W-1:0] phase,
   output logic                  terminal,
   output logic                  illegal
);

   logic                  legal_s;
   logic [JC_PHASE_W-1:0] pop_s;
   logic [JC_PHASE_W:0]   back_s;

   // Phase comes from the popcount: the filling half counts up with the
   // ones, the draining half (LSB still set) counts down from 2*WIDTH.
   always_comb begin
      legal_s  = jc_is_legal(count);
      pop_s    = jc_popcount(count);
      back_s   = (JC_PHASE_W + 1)'(JC_STATES) - {1'b0, pop_s};
      phase    = {JC_PHASE_W{1'b0}};
      terminal = 1'b0;
      illegal  = ~legal_s;
      if (!legal_s) begin
         phase = {JC_PHASE_W{1'b0}};
      end else if (count[0]) begin
         phase = back_s[JC_PHASE_W-1:0];
      end else begin
         phase = pop_s;
      end
      if (legal_s && (count == {{(JC_WIDTH-1){1'b0}}, 1'b1})) begin
         terminal = 1'b1;
      end else begin
         terminal = 1'b0;
      end
   end

endmodule : johnson_phase_decoder

// File: rtl/johnson_counter_8b.sv
// ----------------------------------------------------------------------------
// johnson_counter_8b
// Free-running twisted-ring counter with self-recovery from corrupt states.
//   clk      in  : rising-edge clock
//   reset_n  in  : asynchronous active-low reset, clears the register
//   count    out : registered state
//   phase    out : decoded sequence index (combinational from count)
//   terminal out : high on the final state of the cycle
//   illegal  out : high when the register holds a non-Johnson pattern
// ----------------------------------------------------------------------------
module johnson_counter_8b
   import johnson_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   output logic [JC_WIDTH-1:0]   count,
   output logic [JC_PHASE_W-1:0] phase,
   output logic                  terminal,
   output logic                  illegal
);

   logic [JC_WIDTH-1:0] count_r;
   logic [JC_WIDTH-1:0] next_s;
   logic                illegal_s;

   johnson_phase_decoder u_decoder (
      .count    (count_r),
      .phase    (phase),
      .terminal (terminal),
      .illegal  (illegal_s)
   );

   // Shift with inverted feedback, or drop back to all-zeros from a
   // corrupted pattern so the ring re-enters the legal cycle next edge.
   always_comb begin
      next_s = {JC_WIDTH{1'b0}};
      if (illegal_s) begin
         next_s = {JC_WIDTH{1'b0}};
      end else begin
         next_s = {~count_r[0], count_r[JC_WIDTH-1:1]};
      end
   end

   // State register; reset clears it immediately, independent of clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {JC_WIDTH{1'b0}};
      end else begin
         count_r <= next_s;
      end
   end

   assign count   = count_r;
   assign illegal = illegal_s;

endmodule : johnson_counter_8b

// File: tb/tb_johnson_counter_8b.sv
// ----------------------------------------------------------------------------
// tb_johnson_counter_8b
// Self-checking bench: outputs are compared with a reference that tracks
// the position in the 16-state cycle as a plain integer and derives the
// expected pattern from it.
// ----------------------------------------------------------------------------
module tb_johnson_counter_8b;

   localparam int W = 8;
   localparam int N = 2 * W;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] count;
   logic [3:0]   phase;
   logic         terminal;
   logic         illegal;

   int n_tests;
   int n_fail;
   int idx;

   johnson_counter_8b dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .count    (count),
      .phase    (phase),
      .terminal (terminal),
      .illegal  (illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pattern at cycle position i: first half fills ones from the MSB,
   // second half keeps (2W - i) ones at the LSB end.
   function automatic logic [W-1:0] model_count(input int i);
      logic [W-1:0] v;
      v = '0;
      for (int b = 0; b < W; b++) begin
         if (i <= W) v[b] = (b >= W - i);
         else        v[b] = (b < N - i);
      end
      return v;
   endfunction

   function automatic int model_index(input logic [W-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) begin
         if (model_count(i) == v) r = i;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".count"},    {24'd0, count},    {24'd0, model_count(idx)});
      chk({tag, ".phase"},    {28'd0, phase},    idx);
      chk({tag, ".terminal"}, {31'd0, terminal}, {31'd0, (idx == N - 1)});
      chk({tag, ".illegal"},  {31'd0, illegal},  32'd0);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      @(negedge clk);
      idx = (idx + 1) % N;
      chk_state(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      idx = 0;
      chk_state(tag);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] v;
      int           vi;
      int           n;
      n_tests = 0;
      n_fail  = 0;
      idx     = 0;
      reset_n = 1'b0;

      // power-up reset
      #15;
      chk_state("por");

      // full cycle after release
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) step("cycle");

      // mid-sequence async reset at 11110000
      for (int i = 0; i < 4; i++) step("pre_rst");
      chk({24'd0, count}, {24'd0, count}, {24'd0, 8'hF0}); // guard only on DUT side below
      do_reset("mid_rst");
      step("post_rst");

      // forced illegal pattern
      @(negedge clk);
      force dut.count_r = 8'hA0;
      #1;
      chk("ill.illegal",  {31'd0, illegal},  32'd1);
      chk("ill.phase",    {28'd0, phase},    32'd0);
      chk("ill.terminal", {31'd0, terminal}, 32'd0);
      release dut.count_r;
      idx = N - 1;
      step("ill_rec0");
      step("ill_rec1");

      // random patterns forced into the register
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         v  = W'($urandom_range(0, 255));
         vi = model_index(v);
         force dut.count_r = v;
         #1;
         if (vi < 0) begin
            chk("rnd.illegal", {31'd0, illegal},  32'd1);
            chk("rnd.phase",   {28'd0, phase},    32'd0);
            chk("rnd.term",    {31'd0, terminal}, 32'd0);
            idx = N - 1;
         end else begin
            idx = vi;
            chk_state("rnd.legal");
         end
         release dut.count_r;
         step("rnd.next");
      end

      // random run lengths interrupted by async resets
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(1, 30);
         for (int i = 0; i < n; i++) step("rrun");
         do_reset("rrun_rst");
      end

      // long run: 160 edges from reset
      for (int i = 0; i < 10 * N; i++) step("long");
      chk("long.final", {24'd0, count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_johnson_counter_8b

// File: doc/johnson_counter_8b.md
# johnson_counter_8b

Free-running 8-stage Johnson (twisted-ring) counter with a 16-state cycle, for use as a glitch-free phase or sequence generator. Each clock edge shifts the register right by one bit and feeds the inverted LSB into the MSB. Alongside the raw count, the block outputs a decoded phase index, a terminal-state flag and an illegal-state flag. It recovers from corrupted states on its own.

## Interface
- WIDTH, 8: number of stages; the cycle length is 2*WIDTH. Only 8 needs to be supported, but no value may be hard-coded.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- count  output  WIDTH  register state; bit WIDTH-1 is the MSB
- phase  output  $clog2(2*WIDTH)  index of the current state in the sequence, 0..15
- terminal  output  1  high while count is 00000001 (phase 15)
- illegal  output  1  high while count is not a valid Johnson state

## Operation
- Next state, for a legal current state: next = {~count[0], count[WIDTH-1:1]}.
- Full sequence, one state per clock:
  - 00000000, 10000000, 11000000, 11100000, 11110000, 11111000, 11111100, 11111110
  - 11111111, 01111111, 00111111, 00011111, 00001111, 00000111, 00000011, 00000001
  - then back to 00000000.
- Legal state definition: count is 1^k 0^(WIDTH-k) or 0^k 1^(WIDTH-k), for 0 ≤ k ≤ WIDTH. Equivalently, adjacent bits differ in at most one position.
- Illegal state handling:
  - illegal = 1, combinationally.
  - The next edge loads 00000000 instead of the shifted value.
- Phase decode, with p = popcount(count):
  - phase = p if count[0] == 0.
  - phase = 2*WIDTH - p if count[0] == 1.
  - phase is defined only for legal states. For illegal states it is 0.
- terminal = legal && (count == 1).
- No enable and no load. The counter advances on every edge while out of reset.

## Timing
- Reset:
  - reset_n low forces count = 0 immediately, without waiting for a clock edge.
  - During reset: phase = 0, terminal = 0, illegal = 0.
  - Reset applied mid-sequence behaves the same from any state.
- Release:
  - The first rising edge strictly after reset_n goes high produces 10000000.
  - Release coincident with a clock edge is not supported. Integration must synchronise deassertion so that it lands away from the active edge.
- Latency: count updates on every rising edge. phase, terminal and illegal are combinational from count and valid in the same cycle.
- Wrap-around: the edge after terminal = 1 yields 00000000. This needs no special logic.
- Simultaneous events: reset_n low always overrides the clock edge and illegal-state recovery.

## Structure
- Shared package (johnson_pkg):
  - JC_WIDTH = 8
  - JC_STATES = 2*JC_WIDTH
  - the phase width localparam
- One sub-module, johnson_phase_decoder (combinational). It takes count and produces phase, terminal and illegal.
- The top level holds only the state register and the next-state mux (shift vs. recovery to 0).

## Test plan
- Reset at power-up:
  - Hold reset_n = 0 for 15 ns, with no clock edge required.
  - Expect count = 00000000, phase = 0, terminal = 0, illegal = 0.
- Full cycle:
  - Release reset_n between edges, then apply 16 edges.
  - Expect the sequence 10000000, 11000000, …, 00000001, 00000000.
  - Expect phase 1..15, then 0.
  - Expect terminal high only at 00000001.
- Mid-sequence async reset:
  - Drive reset_n low at 11110000, between edges.
  - Expect count = 0 before the next edge.
  - After release, expect the next edge to give 10000000.
- Illegal recovery:
  - Force the register to 10100000.
  - Expect illegal = 1 and phase = 0.
  - Expect the next edge to give 00000000, then 10000000.
- Long run:
  - Run 160 edges.
  - Expect count = 00000000 (10 full cycles), with illegal never asserted.
